uart_fifo_mirror: RTL and testbench

- Parametrised successor to the single-byte UART echo path.
- Sits between a uart_rx instance and a uart_tx instance. Each received byte is captured into a FIFO of DEPTH entries, optionally transformed per MODE, and retransmitted in order.
- Absorbs back-to-back RX bursts without loss up to DEPTH, and reports fill level and a sticky overflow flag.

---
 rtl/mirror_pkg.sv | 66 ++++++
 rtl/mirror_fifo.sv | 82 ++++++++
 rtl/uart_fifo_mirror.sv | 157 +++++++++++++++
 tb/tb_uart_fifo_mirror.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mirror_pkg.sv
// Shared definitions for the UART FIFO mirror: transform mode codes, the
// TX handshake state type and the byte transform applied on pop.
package mirror_pkg;

  // Transform selectors for the MODE parameter.
  localparam int MODE_ECHO     = 0;
  localparam int MODE_INVERT   = 1;
  localparam int MODE_CASESWAP = 2;

  // Widest data path the transform helper accepts; callers zero-extend
  // into it and truncate the result back to their own width.
  localparam int XF_MAX_W = 64;

  // Saturation ceiling for the 16-bit statistics counters.
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // TX handshake states towards uart_tx.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } tx_state_e;

  // Byte transform applied when a byte leaves the FIFO.
  // Case swap only makes sense for 8-bit ASCII; other widths pass through.
  function automatic logic [XF_MAX_W-1:0] xform(
    input logic [XF_MAX_W-1:0] i_din,
    input int                  i_mode,
    input int                  i_data_w
  );
    logic [XF_MAX_W-1:0] w_out;
    logic                w_is_upper;
    logic                w_is_lower;
    w_out      = i_din;
    w_is_upper = (i_din[7:0] >= 8'h41) && (i_din[7:0] <= 8'h5A);
    w_is_lower = (i_din[7:0] >= 8'h61) && (i_din[7:0] <= 8'h7A);
    case (i_mode)
      MODE_INVERT: begin
        w_out = ~i_din;
      end
      MODE_CASESWAP: begin
        if ((i_data_w == 8) && (w_is_upper || w_is_lower)) begin
          w_out[5] = ~i_din[5];
        end else begin
          w_out = i_din;
        end
      end
      default: begin
        w_out = i_din;
      end
    endcase
    return w_out;
  endfunction

  // 16-bit increment that sticks at the ceiling instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] i_val);
    logic [15:0] w_res;
    if (i_val == STAT_MAX) begin
      w_res = i_val;
    end else begin
      w_res = i_val + 16'd1;
    end
    return w_res;
  endfunction

endpackage : mirror_pkg

// File: rtl/mirror_fifo.sv
// Single-clock synchronous FIFO. A push and a pop in the same cycle both
// take effect even when full, so the occupancy is unchanged and nothing is
// lost. Pointers wrap naturally; occupancy is tracked by an explicit counter
// and full/empty are registered alongside it.
module mirror_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;

  logic              w_wr_en;
  logic              w_rd_en;
  logic [CW-1:0]     w_count_nxt;

  // A pop frees the slot the simultaneous push needs, so full only blocks
  // a push that has no matching pop.
  assign w_rd_en = i_pop && !r_empty;
  assign w_wr_en = i_push && (!r_full || w_rd_en);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == CW'(0));
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_full       = r_full;
  assign o_empty      = r_empty;
  assign o_fill_level = r_count;

endmodule : mirror_fifo

// File: rtl/uart_fifo_mirror.sv
// UART echo path with a DEPTH-entry elastic buffer between uart_rx and
// uart_tx. Bytes are captured on the rising edge of rx_ready, optionally
// transformed (MODE) on their way out, and retransmitted in order.
// Optional build macro: MIRROR_STATS_EN adds saturating rx/tx/drop counters.
// DATA_W must not exceed mirror_pkg::XF_MAX_W.
module uart_fifo_mirror
  import mirror_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int MODE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ready,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   empty,
  output logic                   overflow
`ifdef MIRROR_STATS_EN
  ,
  output logic [15:0]            rx_count,
  output logic [15:0]            tx_count,
  output logic [15:0]            drop_count
`endif
);

  logic                   r_rx_ready_d;
  logic                   r_overflow;
  tx_state_e              r_state;
  logic                   r_tx_start;
  logic [DATA_W-1:0]      r_tx_data;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [DATA_W-1:0]      w_head;
  logic [$clog2(DEPTH):0] w_fill_level;

  // A held ready level must push only once, so capture on its rising edge.
  assign w_push = rx_ready && !r_rx_ready_d;
  // The FSM takes the head only when it is idle and uart_tx is free.
  assign w_pop  = (r_state == IDLE) && !w_empty && !tx_busy;
  // A byte is lost only when full and no slot is freed in the same cycle.
  assign w_drop = w_push && w_full && !w_pop;

  mirror_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_data       (rx_data),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_fill_level (w_fill_level)
  );

  // Previous rx_ready level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready_d <= 1'b0;
    end else begin
      r_rx_ready_d <= rx_ready;
    end
  end

  // Sticky overflow: set on the first dropped byte, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // TX handshake FSM: load a byte, hold start until uart_tx goes busy,
  // then wait for the frame to finish. tx_data only changes on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= DATA_W'(xform(XF_MAX_W'(w_head), MODE, DATA_W));
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          if (tx_busy) begin
            r_tx_start <= 1'b0;
            r_state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign tx_start   = r_tx_start;
  assign tx_data    = r_tx_data;
  assign fill_level = w_fill_level;
  assign empty      = w_empty;
  assign overflow   = r_overflow;

`ifdef MIRROR_STATS_EN
  logic [15:0] r_rx_count;
  logic [15:0] r_tx_count;
  logic [15:0] r_drop_count;

  // Traffic counters: every rx edge, every frame launched, every drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_count   <= 16'd0;
      r_tx_count   <= 16'd0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_push) begin
        r_rx_count <= sat_inc16(r_rx_count);
      end
      if (w_pop) begin
        r_tx_count <= sat_inc16(r_tx_count);
      end
      if (w_drop) begin
        r_drop_count <= sat_inc16(r_drop_count);
      end
    end
  end

  assign rx_count   = r_rx_count;
  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;
`endif

endmodule : uart_fifo_mirror

// File: tb/tb_uart_fifo_mirror.sv
// Bench for uart_fifo_mirror: four instances (echo/16, invert/4,
// case-swap/16, 7-bit case-swap/4), a behavioural uart_tx responder and a
// queue-based model of what must come out of each instance.
module tb_uart_fifo_mirror;

  localparam int DEP [4] = '{16, 4, 16, 4};
  localparam int MOD [4] = '{0, 1, 2, 2};
  localparam int WID [4] = '{8, 8, 8, 7};

  logic       clk = 1'b0;
  logic [3:0] rst;
  logic [3:0] rx_ready;
  logic [3:0] tx_busy;
  logic [7:0] rxd [4];

  wire [3:0]  tx_start;
  wire [3:0]  empty_v;
  wire [3:0]  ovf_v;
  wire [7:0]  txd0, txd1, txd2;
  wire [6:0]  txd3;
  wire [4:0]  fl0, fl2;
  wire [2:0]  fl1, fl3;
`ifdef MIRROR_STATS_EN
  wire [15:0] rxc [4];
  wire [15:0] txc [4];
  wire [15:0] drc [4];
`endif

  logic [7:0] exp_q [4][$];
  logic [7:0] sent_log [4][$];
  bit         mprev [4];
  bit         mov [4];
  bit         stuck [4];
  int         bcnt [4];
  int         flen [4];
  int         tests = 0;
  int         fails = 0;
  int         peak;
  int         k;

  always #5 clk = ~clk;

  uart_fifo_mirror #(.DATA_W(8), .DEPTH(16), .MODE(0)) u_d0 (
    .clk(clk), .rst(rst[0]), .rx_ready(rx_ready[0]), .rx_data(rxd[0]),
    .tx_busy(tx_busy[0]), .tx_start(tx_start[0]), .tx_data(txd0),
    .fill_level(fl0), .empty(empty_v[0]), .overflow(ovf_v[0])
`ifdef MIRROR_STATS_EN
    , .rx_count(rxc[0]), .tx_count(txc[0]), .drop_count(drc[0])
`endif
  );

  uart_fifo_mirror #(.DATA_W(8), .DEPTH(4), .MODE(1)) u_d1 (
    .clk(clk), .rst(rst[1]), .rx_ready(rx_ready[1]), .rx_data(rxd[1]),
    .tx_busy(tx_busy[1]), .tx_start(tx_start[1]), .tx_data(txd1),
    .fill_level(fl1), .empty(empty_v[1]), .overflow(ovf_v[1])
`ifdef MIRROR_STATS_EN
    , .rx_count(rxc[1]), .tx_count(txc[1]), .drop_count(drc[1])
`endif
  );

  uart_fifo_mirror #(.DATA_W(8), .DEPTH(16), .MODE(2)) u_d2 (
    .clk(clk), .rst(rst[2]), .rx_ready(rx_ready[2]), .rx_data(rxd[2]),
    .tx_busy(tx_busy[2]), .tx_start(tx_start[2]), .tx_data(txd2),
    .fill_level(fl2), .empty(empty_v[2]), .overflow(ovf_v[2])
`ifdef MIRROR_STATS_EN
    , .rx_count(rxc[2]), .tx_count(txc[2]), .drop_count(drc[2])
`endif
  );

  uart_fifo_mirror #(.DATA_W(7), .DEPTH(4), .MODE(2)) u_d3 (
    .clk(clk), .rst(rst[3]), .rx_ready(rx_ready[3]), .rx_data(rxd[3][6:0]),
    .tx_busy(tx_busy[3]), .tx_start(tx_start[3]), .tx_data(txd3),
    .fill_level(fl3), .empty(empty_v[3]), .overflow(ovf_v[3])
`ifdef MIRROR_STATS_EN
    , .rx_count(rxc[3]), .tx_count(txc[3]), .drop_count(drc[3])
`endif
  );

  function automatic logic [31:0] get_txd(int i);
    case (i)
      0:       return 32'(txd0);
      1:       return 32'(txd1);
      2:       return 32'(txd2);
      default: return 32'(txd3);
    endcase
  endfunction

  function automatic logic [31:0] get_fill(int i);
    case (i)
      0:       return 32'(fl0);
      1:       return 32'(fl1);
      2:       return 32'(fl2);
      default: return 32'(fl3);
    endcase
  endfunction

  // Expected output byte: invert, or swap letter case by +/-32 on ASCII.
  function automatic logic [7:0] model_x(int i, logic [7:0] din);
    logic [7:0] m;
    logic [7:0] d;
    m = (WID[i] == 8) ? 8'hFF : 8'h7F;
    d = din & m;
    if (MOD[i] == 1) return (~d) & m;
    if (MOD[i] == 2 && WID[i] == 8) begin
      if (d >= 8'd65 && d <= 8'd90)  return d + 8'd32;
      if (d >= 8'd97 && d <= 8'd122) return d - 8'd32;
    end
    return d;
  endfunction

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, expv);
    end
  endtask

  // One clock: model rx edges, respond as uart_tx, compare occupancy/flags.
  task automatic tick();
    bit         ev [4];
    bit         rs [4];
    int         sz [4];
    logic [7:0] d [4];
    bit         popped;
    for (int i = 0; i < 4; i++) begin
      rs[i]    = rst[i];
      ev[i]    = rx_ready[i] && !mprev[i] && !rst[i];
      mprev[i] = rst[i] ? 1'b0 : rx_ready[i];
      d[i]     = rxd[i];
      sz[i]    = exp_q[i].size();
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rs[i]) begin
        exp_q[i].delete();
        mov[i]     = 1'b0;
        bcnt[i]    = 0;
        tx_busy[i] = stuck[i];
      end else begin
        popped = 1'b0;
        if (stuck[i]) begin
          tx_busy[i] = 1'b1;
        end else if (bcnt[i] > 0) begin
          bcnt[i]--;
          if (bcnt[i] == 0) tx_busy[i] = 1'b0;
        end else if (tx_start[i] && !tx_busy[i]) begin
          chk("tx_data", i, get_txd(i), (exp_q[i].size() > 0) ? 32'(exp_q[i][0]) : 32'h100);
          if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
          sent_log[i].push_back(8'(get_txd(i)));
          popped     = 1'b1;
          tx_busy[i] = 1'b1;
          bcnt[i]    = flen[i];
        end
        if (ev[i]) begin
          if (sz[i] == DEP[i] && !popped) mov[i] = 1'b1;
          else exp_q[i].push_back(model_x(i, d[i]));
        end
        chk("fill", i, get_fill(i), 32'(exp_q[i].size()));
        chk("overflow", i, 32'(ovf_v[i]), 32'(mov[i]));
        chk("empty", i, 32'(empty_v[i]), 32'(exp_q[i].size() == 0));
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input int hold, input int gap);
    rx_ready[i] = 1'b1;
    rxd[i]      = d;
    repeat (hold) tick();
    rx_ready[i] = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while ((exp_q[i].size() != 0 || tx_busy[i]) && n < 5000) begin
      tick();
      n++;
    end
    chk("drain_done", i, 32'(n < 5000), 32'd1);
    repeat (3) tick();
  endtask

  task automatic reset_one(input int i);
    rst[i] = 1'b1;
    tick();
    rst[i] = 1'b0;
  endtask

  initial begin
    rst      = 4'hF;
    rx_ready = 4'h0;
    tx_busy  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      rxd[i] = 8'h00; mprev[i] = 1'b0; mov[i] = 1'b0;
      stuck[i] = 1'b0; bcnt[i] = 0; flen[i] = 3;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx_start", i, 32'(tx_start[i]), 32'd0);
      chk("rst_tx_data", i, get_txd(i), 32'd0);
      chk("rst_fill", i, get_fill(i), 32'd0);
      chk("rst_empty", i, 32'(empty_v[i]), 32'd1);
      chk("rst_overflow", i, 32'(ovf_v[i]), 32'd0);
    end
    rst = 4'h0;
    tick();

    // Single byte: start two cycles after the edge cycle.
    flen[0] = 20;
    rx_ready[0] = 1'b1;
    rxd[0] = 8'h5A;
    tick();
    rx_ready[0] = 1'b0;
    chk("lat_fill1", 0, get_fill(0), 32'd1);
    chk("lat_nostart", 0, 32'(tx_start[0]), 32'd0);
    tick();
    chk("lat_start", 0, 32'(tx_start[0]), 32'd1);
    chk("lat_data", 0, get_txd(0), 32'h5A);
    chk("lat_fill0", 0, get_fill(0), 32'd0);
    drain(0);
    chk("single_ovf", 0, 32'(ovf_v[0]), 32'd0);

    // Burst of 16 bytes every 3 cycles with long frames.
    flen[0] = 100;
    sent_log[0].delete();
    peak = 0;
    for (int b = 0; b < 16; b++) begin
      push(0, 8'(b), 1, 2);
      if (int'(get_fill(0)) > peak) peak = int'(get_fill(0));
    end
    drain(0);
    chk("burst_count", 0, 32'(sent_log[0].size()), 32'd16);
    for (int b = 0; b < 16 && b < sent_log[0].size(); b++)
      chk("burst_order", b, 32'(sent_log[0][b]), 32'(b));
    chk("burst_peak", 0, 32'(peak <= 16), 32'd1);
    chk("burst_ovf", 0, 32'(ovf_v[0]), 32'd0);

    // Ready held for 10 cycles pushes once.
    flen[0] = 3;
    sent_log[0].delete();
    push(0, 8'h33, 10, 0);
    drain(0);
    chk("held_count", 0, 32'(sent_log[0].size()), 32'd1);
    chk("held_data", 0, (sent_log[0].size() > 0) ? 32'(sent_log[0][0]) : 32'h100, 32'h33);

    // Transform modes.
    push(1, 8'h0F, 1, 0);
    drain(1);
    chk("invert", 1, (sent_log[1].size() > 0) ? 32'(sent_log[1][0]) : 32'h100, 32'hF0);
    push(2, 8'h61, 1, 1);
    push(2, 8'h5A, 1, 1);
    push(2, 8'h35, 1, 1);
    drain(2);
    chk("swap_count", 2, 32'(sent_log[2].size()), 32'd3);
    if (sent_log[2].size() == 3) begin
      chk("swap_a", 2, 32'(sent_log[2][0]), 32'h41);
      chk("swap_Z", 2, 32'(sent_log[2][1]), 32'h7A);
      chk("swap_5", 2, 32'(sent_log[2][2]), 32'h35);
    end
    push(3, 8'h61, 1, 1);
    push(3, 8'h5A, 1, 1);
    drain(3);
    chk("w7_count", 3, 32'(sent_log[3].size()), 32'd2);
    if (sent_log[3].size() == 2) begin
      chk("w7_a", 3, 32'(sent_log[3][0]), 32'h61);
      chk("w7_Z", 3, 32'(sent_log[3][1]), 32'h5A);
    end

    // Overflow: DEPTH 4, uart_tx stuck busy, 6 bytes offered.
    stuck[1] = 1'b1;
    reset_one(1);
    sent_log[1].delete();
    for (int b = 0; b < 6; b++) push(1, 8'(8'h10 + b), 1, 1);
    chk("ovf_fill", 1, get_fill(1), 32'd4);
    chk("ovf_flag", 1, 32'(ovf_v[1]), 32'd1);
    stuck[1] = 1'b0;
    tx_busy[1] = 1'b0;
    drain(1);
    chk("ovf_sent", 1, 32'(sent_log[1].size()), 32'd4);
    for (int b = 0; b < 4 && b < sent_log[1].size(); b++)
      chk("ovf_data", b, 32'(sent_log[1][b]), 32'(8'hEF - b));
    chk("ovf_sticky", 1, 32'(ovf_v[1]), 32'd1);
`ifdef MIRROR_STATS_EN
    chk("stat_rx", 1, 32'(rxc[1]), 32'd6);
    chk("stat_drop", 1, 32'(drc[1]), 32'd2);
    chk("stat_tx", 1, 32'(txc[1]), 32'd4);
`endif

    // Full FIFO: push and pop in the same cycle loses nothing.
    stuck[1] = 1'b1;
    reset_one(1);
    sent_log[1].delete();
    for (int b = 0; b < 4; b++) push(1, 8'(8'h20 + b), 1, 1);
    stuck[1] = 1'b0;
    tx_busy[1] = 1'b0;
    rx_ready[1] = 1'b1;
    rxd[1] = 8'h24;
    tick();
    rx_ready[1] = 1'b0;
    chk("pp_fill", 1, get_fill(1), 32'd4);
    chk("pp_ovf", 1, 32'(ovf_v[1]), 32'd0);
    chk("pp_start", 1, 32'(tx_start[1]), 32'd1);
    drain(1);
    chk("pp_sent", 1, 32'(sent_log[1].size()), 32'd5);
    chk("pp_last", 1, (sent_log[1].size() > 0) ? 32'(sent_log[1][$]) : 32'h100, 32'hDB);

    // Reset while in START with 3 bytes queued.
    stuck[0] = 1'b1;
    tx_busy[0] = 1'b1;
    for (int b = 0; b < 4; b++) push(0, 8'(8'h40 + b), 1, 1);
    stuck[0] = 1'b0;
    tx_busy[0] = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!tx_start[0] && k < 10);
    chk("mid_start_seen", 0, 32'(tx_start[0]), 32'd1);
    chk("mid_queued", 0, get_fill(0), 32'd3);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("mid_tx_start", 0, 32'(tx_start[0]), 32'd0);
    chk("mid_fill", 0, get_fill(0), 32'd0);
    chk("mid_empty", 0, 32'(empty_v[0]), 32'd1);
    chk("mid_ovf", 0, 32'(ovf_v[0]), 32'd0);
    repeat (5) tick();

    // Randomised traffic on every instance, drops predicted by the model.
    rst = 4'hF;
    tick();
    rst = 4'h0;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        flen[i] = int'($urandom_range(1, 8));
        rx_ready[i] = 1'b1;
        rxd[i] = 8'($urandom);
      end
      repeat ($urandom_range(1, 3)) tick();
      rx_ready = 4'h0;
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int i = 0; i < 4; i++) drain(i);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_fifo_mirror
